// File: rtl/truth_table_sequencer_if.sv
// Shared bus between the truth-table sequencer (slave) and the bench or
// harness that owns the two function implementations (master).
interface truth_table_sequencer_if #(
  parameter int N_IN = 4
);
  logic                 start;
  logic [N_IN-1:0]      abcd;
  logic                 fa;
  logic                 fb;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_a;
  logic [2**N_IN-1:0]   table_b;
  logic                 mismatch;
  logic [N_IN-1:0]      first_bad;

  modport master (
    output start, fa, fb,
    input  abcd, busy, done, table_a, table_b, mismatch, first_bad
  );

  modport slave (
    input  start, fa, fb,
    output abcd, busy, done, table_a, table_b, mismatch, first_bad
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps a 2**N_IN-entry input space, records two candidate outputs per vector
// and flags the lowest disagreeing index. Optional macro: STOP_ON_MISMATCH_EN.
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_sequencer_if.slave  bus
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST     = N_IN'(NV - 1);
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      hold_cnt;
  logic [N_IN-1:0] abcd_r;
  logic [N_IN-1:0] first_bad_r;
  logic [NV-1:0]   table_a_r;
  logic [NV-1:0]   table_b_r;
  logic            busy_r;
  logic            done_r;
  logic            mismatch_r;
  logic            busy_d;
  logic            done_d;
  logic            accept;
  logic            last_vec;
  logic            stop_now;
  state_t          vec_entry;

  assign accept    = (state == IDLE) && bus.start;
  assign last_vec  = (abcd_r == LAST);
  // With no settle time a vector is sampled on the very next edge.
  assign vec_entry = (SETTLE_C == 4'd0) ? SAMPLE : HOLD;

`ifdef STOP_ON_MISMATCH_EN
  logic sample_bad;
  assign sample_bad = (state == SAMPLE) && (bus.fa != bus.fb);
  assign stop_now   = sample_bad;
`else
  assign stop_now   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = vec_entry;
      HOLD:    if (({1'b0, hold_cnt} + 5'd1) >= {1'b0, SETTLE_C}) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (last_vec || stop_now) ? DONE : vec_entry;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered, so they lag the state by one edge: done lands
  // in the cycle after DONE, together with busy falling.
  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hold_cnt    <= 4'd0;
      abcd_r      <= '0;
      table_a_r   <= '0;
      table_b_r   <= '0;
      mismatch_r  <= 1'b0;
      first_bad_r <= '0;
    end else begin
      busy_r <= busy_d;
      done_r <= done_d;
      if (accept) begin
        abcd_r      <= '0;
        hold_cnt    <= 4'd0;
        table_a_r   <= '0;
        table_b_r   <= '0;
        mismatch_r  <= 1'b0;
        first_bad_r <= '0;
      end else begin
        case (state)
          HOLD: hold_cnt <= hold_cnt + 4'd1;
          SAMPLE: begin
            table_a_r[abcd_r] <= bus.fa;
            table_b_r[abcd_r] <= bus.fb;
            if ((bus.fa != bus.fb) && !mismatch_r) begin
              mismatch_r  <= 1'b1;
              first_bad_r <= abcd_r;
            end
            hold_cnt <= 4'd0;
            abcd_r   <= (state_nxt == DONE) ? '0 : abcd_r + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.abcd      = abcd_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.table_a   = table_a_r;
  assign bus.table_b   = table_b_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.first_bad = first_bad_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Table-driven bench for truth_table_sequencer: SETTLE=1 and SETTLE=0 instances.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N_IN(4)) b0();
  truth_table_sequencer_if #(.N_IN(4)) b1();

  truth_table_sequencer #(.N_IN(4), .SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  truth_table_sequencer #(.N_IN(4), .SETTLE(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int total = 0;
  int bad   = 0;
  int mode0 = 0;
  int mode1 = 0;
  int sel   = 0;

  function automatic logic [1:0] pat(input int m, input logic [3:0] v);
    logic a, b;
    case (m)
      0: begin a = v[0];  b = v[0]; end
      1: begin a = ~v[0]; b = a | (v == 4'd5) | (v == 4'd12); end
      2: begin a = 1'b1;  b = 1'b1; end
      3: begin a = 1'b0;  b = 1'b1; end
      4: begin a = v[3];  b = v[3] & (v != 4'd15); end
      default: begin a = 1'b0; b = 1'b0; end
    endcase
    return {a, b};
  endfunction

  assign {b0.fa, b0.fb} = pat(mode0, b0.abcd);
  assign {b1.fa, b1.fb} = pat(mode1, b1.abcd);

  logic        cur_done, cur_busy, cur_mm;
  logic [3:0]  cur_abcd, cur_fbad;
  logic [15:0] cur_ta, cur_tb;
  assign cur_done = sel ? b1.done      : b0.done;
  assign cur_busy = sel ? b1.busy      : b0.busy;
  assign cur_mm   = sel ? b1.mismatch  : b0.mismatch;
  assign cur_abcd = sel ? b1.abcd      : b0.abcd;
  assign cur_fbad = sel ? b1.first_bad : b0.first_bad;
  assign cur_ta   = sel ? b1.table_a   : b0.table_a;
  assign cur_tb   = sel ? b1.table_b   : b0.table_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) b1.start = v;
    else          b0.start = v;
  endtask

  // Pulses start, then watches a fixed window of edges after the start edge.
  task automatic run_sweep(input int window, input bit poke,
                           output int first_done, output int dones,
                           output logic busy_at_done, output logic busy_early);
    bit poked;
    poked = 0;
    first_done = -1;
    dones = 0;
    busy_at_done = 1'b1;
    busy_early = 1'b0;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    for (int c = 1; c <= window; c++) begin
      @(posedge clk);
      #1;
      set_start(1'b0);
      if (c == 1) busy_early = cur_busy;
      if (cur_done) begin
        dones++;
        if (first_done < 0) begin
          first_done = c;
          busy_at_done = cur_busy;
        end
      end
      if (poke && !poked && cur_abcd == 4'd7) begin
        poked = 1;
        set_start(1'b1);
      end
    end
  endtask

  typedef struct {
    int          mode;
    logic [15:0] ta;
    logic [15:0] tb;
    logic        mm;
    logic [3:0]  fbad;
    int          dcyc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fd, nd;
    logic bd, be;
    bit found;

    vecs[0] = '{mode: 0, ta: 16'hAAAA, tb: 16'hAAAA, mm: 1'b0, fbad: 4'd0,  dcyc: 33};
`ifdef STOP_ON_MISMATCH_EN
    vecs[1] = '{mode: 1, ta: 16'h0015, tb: 16'h0035, mm: 1'b1, fbad: 4'd5,  dcyc: 13};
    vecs[2] = '{mode: 3, ta: 16'h0000, tb: 16'h0001, mm: 1'b1, fbad: 4'd0,  dcyc: 3};
`else
    vecs[1] = '{mode: 1, ta: 16'h5555, tb: 16'h5575, mm: 1'b1, fbad: 4'd5,  dcyc: 33};
    vecs[2] = '{mode: 3, ta: 16'h0000, tb: 16'hFFFF, mm: 1'b1, fbad: 4'd0,  dcyc: 33};
`endif
    vecs[3] = '{mode: 4, ta: 16'hFF00, tb: 16'h7F00, mm: 1'b1, fbad: 4'd15, dcyc: 33};

    b0.start = 1'b0;
    b1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(b0.busy), 32'd0);
    check("rst_done",  32'(b0.done), 32'd0);
    check("rst_abcd",  32'(b0.abcd), 32'd0);
    check("rst_mm",    32'(b0.mismatch), 32'd0);
    check("rst_table", 32'({b0.table_a, b0.table_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    for (int i = 0; i < 4; i++) begin
      mode0 = vecs[i].mode;
      run_sweep(40, 1'b0, fd, nd, bd, be);
      check($sformatf("v%0d_busy_early", i), 32'(be), 32'd1);
      check($sformatf("v%0d_done_cyc", i), 32'(fd), 32'(vecs[i].dcyc));
      check($sformatf("v%0d_done_cnt", i), 32'(nd), 32'd1);
      check($sformatf("v%0d_busy_at_done", i), 32'(bd), 32'd0);
      check($sformatf("v%0d_table_a", i), 32'(cur_ta), 32'(vecs[i].ta));
      check($sformatf("v%0d_table_b", i), 32'(cur_tb), 32'(vecs[i].tb));
      check($sformatf("v%0d_mismatch", i), 32'(cur_mm), 32'(vecs[i].mm));
      if (vecs[i].mm) check($sformatf("v%0d_first_bad", i), 32'(cur_fbad), 32'(vecs[i].fbad));
      check($sformatf("v%0d_abcd_idle", i), 32'(cur_abcd), 32'd0);
    end

    // A second start mid-sweep must not restart or queue a sweep.
    mode0 = 0;
    run_sweep(60, 1'b1, fd, nd, bd, be);
    check("ign_done_cyc", 32'(fd), 32'd33);
    check("ign_done_cnt", 32'(nd), 32'd1);
    check("ign_table_a",  32'(b0.table_a), 32'h0000AAAA);

    // Asynchronous reset in the middle of a sweep.
    mode0 = 0;
    @(negedge clk);
    b0.start = 1'b1;
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (b0.abcd == 4'd9) found = 1;
    end
    check("rst9_reached", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst9_busy",  32'(b0.busy), 32'd0);
    check("rst9_abcd",  32'(b0.abcd), 32'd0);
    check("rst9_table", 32'(b0.table_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(40, 1'b0, fd, nd, bd, be);
    check("rst9_done_cyc", 32'(fd), 32'd33);
    check("rst9_table_a",  32'(b0.table_a), 32'h0000AAAA);

    // SETTLE=0 instance: one vector per cycle.
    sel = 1;
    mode1 = 2;
    run_sweep(24, 1'b0, fd, nd, bd, be);
    check("s0_done_cyc", 32'(fd), 32'd17);
    check("s0_done_cnt", 32'(nd), 32'd1);
    check("s0_table_a",  32'(b1.table_a), 32'h0000FFFF);
    check("s0_mismatch", 32'(b1.mismatch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
